// File: rtl/even_parity_serial_tx.sv
// rtl/even_parity_serial_tx.sv - serial transmitter framing each word as start, data LSB-first, even parity, stop
module even_parity_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CLK_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              accept;
    logic              bit_end;

    assign in_ready   = (state_q == S_IDLE) & ~rst;
    assign accept     = in_valid & in_ready;
    assign bit_end    = (clk_cnt_q == CLK_LAST);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) & bit_end;
    assign tx         = tx_q;

    // Next-state, bit timing and the line level that the next state will drive.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = 1'b1;

        if (state_q == S_IDLE) begin
            if (accept) begin
                state_d   = S_START;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                shift_d   = in_data;
                parity_d  = ^in_data;
            end
        end else if (!bit_end) begin
            clk_cnt_d = clk_cnt_q + 1'b1;
        end else begin
            clk_cnt_d = '0;
            case (state_q)
                S_START: state_d = S_DATA;
                S_DATA: begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                S_PARITY: state_d = S_STOP;
                default:  state_d = S_IDLE;
            endcase
        end

        // tx is registered, so it is derived from the upcoming state and data.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

endmodule
